// File: rtl/viterbi_pkg.sv
// Shared constants and types for the rate-1/2 K=7 convolutional encoder and Viterbi decoder.
package viterbi_pkg;

    localparam int             K          = 7;
    localparam logic [K-1:0]   G0         = 7'o171;
    localparam logic [K-1:0]   G1         = 7'o133;
    localparam int             TAIL_LEN   = K - 1;
    localparam int             NUM_STATES = 2 ** (K - 1);

    // Bit positions inside a code pair, shared by TX parity and RX branch labels
    localparam int PAIR_G0_BIT = 0;
    localparam int PAIR_G1_BIT = 1;

    typedef enum logic {
        RUN,
        TAIL
    } enc_state_t;

endpackage

// File: rtl/conv_enc_parity.sv
// Combinational parity of one K-bit encoder window against both generators.
module conv_enc_parity #(
    parameter int           K  = viterbi_pkg::K,
    parameter logic [K-1:0] G0 = viterbi_pkg::G0,
    parameter logic [K-1:0] G1 = viterbi_pkg::G1
) (
    input  logic [K-1:0] w,
    output logic [1:0]   pair
);
    import viterbi_pkg::*;

    always_comb begin
        pair              = '0;
        pair[PAIR_G0_BIT] = ^(w & G0);
        pair[PAIR_G1_BIT] = ^(w & G1);
    end

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2 feedforward convolutional encoder with optional zero-tail frame termination.
module conv_encoder #(
    parameter int           K       = viterbi_pkg::K,
    parameter logic [K-1:0] G0      = viterbi_pkg::G0,
    parameter logic [K-1:0] G1      = viterbi_pkg::G1,
    parameter bit           TAIL_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_bit,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_pair,
    output logic       out_last
);
    import viterbi_pkg::*;

    localparam int TW = $clog2(K);

    enc_state_t      state, state_nx;
    logic [TW-1:0]   tail_cnt, tail_cnt_nx;
    logic [K-2:0]    sr, sr_nx;
    logic            last_nx;
    logic            step;
    logic            b;
    logic [K-1:0]    w;
    logic [1:0]      pair;

    assign in_ready = (state == RUN) && (!out_valid || out_ready);
    assign step     = (!out_valid || out_ready) && ((state == TAIL) || in_valid);
    assign b        = (state == RUN) ? in_bit : 1'b0;
    assign w        = {b, sr};

    conv_enc_parity #(
        .K  (K),
        .G0 (G0),
        .G1 (G1)
    ) u_parity (
        .w    (w),
        .pair (pair)
    );

    // Next-state values are only committed on a step
    always_comb begin
        state_nx    = state;
        tail_cnt_nx = tail_cnt;
        sr_nx       = w[K-1:1];
        last_nx     = 1'b0;
        case (state)
            RUN: begin
                if (in_last) begin
                    if (TAIL_EN) begin
                        state_nx    = TAIL;
                        tail_cnt_nx = '0;
                    end else begin
                        last_nx = 1'b1;
                        sr_nx   = '0;
                    end
                end
            end
            TAIL: begin
                tail_cnt_nx = tail_cnt + 1'b1;
                if (tail_cnt == TW'(K - 2)) begin
                    last_nx  = 1'b1;
                    state_nx = RUN;
                end
            end
            default: state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            tail_cnt  <= '0;
            sr        <= '0;
            out_valid <= 1'b0;
            out_pair  <= '0;
            out_last  <= 1'b0;
        end else if (step) begin
            state     <= state_nx;
            tail_cnt  <= tail_cnt_nx;
            sr        <= sr_nx;
            out_valid <= 1'b1;
            out_pair  <= pair;
            out_last  <= last_nx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_encoder.sv
// Scoreboard bench for conv_encoder against a bit-history reference model.
module tb_conv_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       in_bit;
    logic       in_last;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [1:0] out_pair;
    logic       out_last;

    always #5 clk = ~clk;

    conv_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bit    (in_bit),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pair  (out_pair),
        .out_last  (out_last)
    );

    typedef struct packed {
        logic [1:0] pair;
        logic       last;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   hist[$];
    int   fbits[$];
    int   pairs_seen = 0;
    int   ready_mode = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    bit   prev_stall = 1'b0;
    logic [1:0] prev_pair;
    logic       prev_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Code pair from the generator polynomials: tap j multiplies the bit sent j steps ago
    function automatic logic [1:0] ref_pair(input int b);
        int   g0 = 'o171;
        int   g1 = 'o133;
        logic p0 = 1'b0;
        logic p1 = 1'b0;
        for (int j = 0; j < 7; j++) begin
            int bj;
            if (j == 0) bj = b;
            else if (j <= hist.size()) bj = hist[hist.size() - j];
            else bj = 0;
            if (((g0 >> (6 - j)) & 1) != 0 && bj != 0) p0 = ~p0;
            if (((g1 >> (6 - j)) & 1) != 0 && bj != 0) p1 = ~p1;
        end
        return {p1, p0};
    endfunction

    task automatic model_accept(input int b, input bit last);
        exp_q.push_back('{pair: ref_pair(b), last: 1'b0});
        hist.push_back(b);
        if (last) begin
            for (int t = 0; t < 6; t++) begin
                exp_q.push_back('{pair: ref_pair(0), last: (t == 5)});
                hist.push_back(0);
            end
            hist.delete();
        end
    endtask

    always @(posedge clk) begin
        #1;
        cyc++;
        case (ready_mode)
            1:       out_ready = (cyc % 3 == 0);
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b1;
        endcase
    end

    always @(negedge clk) begin
        if (!rst && mon_en) begin
            exp_t e;
            if (prev_stall)
                check("stall_hold", {29'd0, out_valid, out_last, out_pair}, {29'd0, 1'b1, prev_last, prev_pair});
            if (out_valid && !out_ready)
                check("in_ready_stall", {31'd0, in_ready}, 32'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pair actual=%0b required=none", out_pair);
                end else begin
                    e = exp_q.pop_front();
                    check("pair", {30'd0, out_pair}, {30'd0, e.pair});
                    check("last", {31'd0, out_last}, {31'd0, e.last});
                end
                pairs_seen++;
            end
            prev_stall = out_valid && !out_ready;
            prev_pair  = out_pair;
            prev_last  = out_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic send_frame(input bit gaps);
        for (int i = 0; i < fbits.size(); i++) begin
            bit acc = 1'b0;
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_bit   = 1'(fbits[i]);
            in_last  = (i == fbits.size() - 1);
            for (int c = 0; c < 500 && !acc; c++) begin
                @(negedge clk);
                acc = in_ready;
                if (acc) model_accept(fbits[i], in_last);
                @(posedge clk);
                #1;
            end
            if (!acc) begin
                errors++;
                $display("FAIL accept_timeout actual=no_handshake required=handshake");
                $fatal(1, "input handshake timeout");
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 3000 && exp_q.size() != 0; c++) @(negedge clk);
        check("drain_empty", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int tail_low;
        int base;
        bit hit;
        rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_pair",  {30'd0, out_pair},  32'd0);
        check("rst_out_last",  {31'd0, out_last},  32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // impulse
        fbits = '{1};
        send_frame(1'b0);
        drain();

        // all-zero frame, tail length seen on in_ready
        fbits = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        send_frame(1'b0);
        tail_low = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (in_ready) break;
            tail_low++;
        end
        check("tail_in_ready_low", tail_low, 32'd6);
        drain();

        // back-to-back impulses
        fbits = '{1};
        send_frame(1'b0);
        send_frame(1'b0);
        drain();

        // backpressure
        ready_mode = 1;
        fbits = '{1};
        send_frame(1'b0);
        drain();
        ready_mode = 0;
        @(posedge clk);
        #1;

        // reset mid-tail after the third pair
        base = pairs_seen;
        fbits = '{1};
        send_frame(1'b0);
        hit = 1'b0;
        for (int c = 0; c < 50 && !hit; c++) begin
            @(negedge clk);
            #1;
            hit = (pairs_seen >= base + 3);
        end
        check("third_pair_seen", {31'd0, hit}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midtail_rst_valid", {31'd0, out_valid}, 32'd0);
        check("midtail_rst_last",  {31'd0, out_last},  32'd0);
        exp_q.delete();
        hist.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("after_rst_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        send_frame(1'b0);
        drain();

        // random frames with random gaps and backpressure
        ready_mode = 2;
        for (int f = 0; f < 80; f++) begin
            int n = $urandom_range(1, 40);
            fbits.delete();
            for (int i = 0; i < n; i++) fbits.push_back(int'($urandom_range(0, 1)));
            send_frame(1'b1);
        end
        drain();
        ready_mode = 0;

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
